// File: rtl/timer_pkg.sv
// Shared definitions for the BCD down-timer: digit width, digit type and
// the per-digit modulus rule used by both the digit cells and load checking.
package timer_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  // Digit 1 is the seconds-tens digit in minutes:seconds mode and rolls at 6.
  function automatic bcd_t digit_mod(input int i, input logic mmss);
    if (mmss && (i == 32'sd1)) begin
      return 4'd6;
    end else begin
      return 4'd10;
    end
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decimal digit stage of the down-timer: loads a preset, steps down by one
// when its lower digits have all reached zero, and reports a borrow upward.
module bcd_digit_cell
  import timer_pkg::*;
#(
  parameter bcd_t MOD = 4'd10
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  bcd_t load_val,
  input  logic dec,
  input  logic borrow_in,
  output bcd_t q,
  output logic is_zero,
  output logic borrow_out
);

  logic step_s;
  bcd_t q_r;

  assign step_s     = dec & borrow_in;
  assign is_zero    = (q_r == 4'd0);
  assign borrow_out = step_s & is_zero;
  assign q          = q_r;

  // Digit register; an out-of-range value is cleared on its next step.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_r <= 4'd0;
    end else if (load) begin
      q_r <= load_val;
    end else if (step_s) begin
      if (q_r == 4'd0) begin
        q_r <= MOD - 4'd1;
      end else if (q_r >= MOD) begin
        q_r <= 4'd0;
      end else begin
        q_r <= q_r - 4'd1;
      end
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down-counter with optional mm:ss digit rollover, preset load
// validation, terminal-count pulse and zero flag for the oven control FSM.
module bcd_down_timer
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int MMSS_MODE    = 1,
  parameter int STOP_AT_ZERO = 1
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic [BCD_W*NUM_DIGITS-1:0] data,
  input  logic                        loadn,
  input  logic                        en,
  output logic [BCD_W*NUM_DIGITS-1:0] count,
  output logic                        tc,
  output logic                        zero,
  output logic                        load_err
);

  localparam logic MMSS_EFF = (MMSS_MODE != 0) && (NUM_DIGITS >= 2);
  localparam logic HOLD_ZERO = (STOP_AT_ZERO != 0);

  logic [NUM_DIGITS-1:0] zero_vec_s;
  logic [NUM_DIGITS-1:0] borrow_s;
  logic [NUM_DIGITS-1:0] bin_s;
  logic                  load_ok_s;
  logic                  load_s;
  logic                  do_dec_s;
  logic                  upper_zero_s;
  logic                  tc_next_s;
  logic                  tc_r;
  logic                  load_err_r;
  bcd_t                  lsd_s;

  assign zero     = &zero_vec_s;
  assign load_s   = !loadn && load_ok_s;
  assign do_dec_s = loadn && en && !(HOLD_ZERO && zero);
  assign lsd_s    = count[BCD_W-1:0];
  assign tc       = tc_r;
  assign load_err = load_err_r;

  genvar i;
  generate
    for (i = 0; i < NUM_DIGITS; i++) begin : g_digit
      if (i == 0) begin : g_lsd
        assign bin_s[i] = 1'b1;
      end else begin : g_upper
        assign bin_s[i] = borrow_s[i-1];
      end

      bcd_digit_cell #(
        .MOD(digit_mod(i, MMSS_EFF))
      ) u_cell (
        .clk       (clk),
        .clr       (clr),
        .load      (load_s),
        .load_val  (data[i*BCD_W +: BCD_W]),
        .dec       (do_dec_s),
        .borrow_in (bin_s[i]),
        .q         (count[i*BCD_W +: BCD_W]),
        .is_zero   (zero_vec_s[i]),
        .borrow_out(borrow_s[i])
      );
    end
  endgenerate

  // Preset is accepted only if every digit is below its own modulus.
  always_comb begin
    load_ok_s = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (data[d*BCD_W +: BCD_W] >= digit_mod(d, MMSS_EFF)) begin
        load_ok_s = 1'b0;
      end else begin
        load_ok_s = load_ok_s;
      end
    end
  end

  // Decrement lands on all-zero when only the least significant digit is 1
  // (or out of range); a borrow out of the top digit means a wrap instead.
  always_comb begin
    upper_zero_s = 1'b1;
    for (int d = 1; d < NUM_DIGITS; d++) begin
      upper_zero_s = upper_zero_s & zero_vec_s[d];
    end
    tc_next_s = do_dec_s && upper_zero_s && !borrow_s[NUM_DIGITS-1] &&
                ((lsd_s == 4'd1) || (lsd_s >= 4'd10));
  end

  // One-cycle event pulses for terminal count and rejected load.
  always_ff @(posedge clk) begin
    if (clr) begin
      tc_r       <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      tc_r       <= tc_next_s;
      load_err_r <= !loadn && !load_ok_s;
    end
  end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed self-checking bench for bcd_down_timer: a stop-at-zero instance and
// a wrap instance share stimulus; expectations are hand-computed BCD values.
module tb_bcd_down_timer;

  logic        clk;
  logic        clr;
  logic [15:0] data;
  logic        loadn;
  logic        en;
  logic [15:0] count;
  logic        tc;
  logic        zero;
  logic        load_err;
  logic [15:0] w_count;
  logic        w_tc;
  logic        w_zero;
  logic        w_load_err;

  int checks;
  int errors;

  bcd_down_timer #(.NUM_DIGITS(4), .MMSS_MODE(1), .STOP_AT_ZERO(1)) dut (
    .clk(clk), .clr(clr), .data(data), .loadn(loadn), .en(en),
    .count(count), .tc(tc), .zero(zero), .load_err(load_err)
  );

  bcd_down_timer #(.NUM_DIGITS(4), .MMSS_MODE(1), .STOP_AT_ZERO(0)) dut_wrap (
    .clk(clk), .clr(clr), .data(data), .loadn(loadn), .en(en),
    .count(w_count), .tc(w_tc), .zero(w_zero), .load_err(w_load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle(input logic c, input logic ln, input logic e, input logic [15:0] d);
    clr = c; loadn = ln; en = e; data = d;
    @(posedge clk);
    #1;
    clr = 1'b0; loadn = 1'b1; en = 1'b0;
  endtask

  task automatic chk(input string name, input logic [15:0] exp_count,
                     input logic exp_tc, input logic exp_zero, input logic exp_err);
    checks++;
    if (count !== exp_count) begin
      errors++; $display("FAIL %s count: got %h expected %h", name, count, exp_count);
    end
    checks++;
    if (tc !== exp_tc) begin
      errors++; $display("FAIL %s tc: got %b expected %b", name, tc, exp_tc);
    end
    checks++;
    if (zero !== exp_zero) begin
      errors++; $display("FAIL %s zero: got %b expected %b", name, zero, exp_zero);
    end
    checks++;
    if (load_err !== exp_err) begin
      errors++; $display("FAIL %s load_err: got %b expected %b", name, load_err, exp_err);
    end
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b0, 16'h1234);
    chk("preload", 16'h1234, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("reset", 16'h0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_mmss_borrow();
    cycle(1'b0, 1'b0, 1'b0, 16'h0100);
    chk("load_0100", 16'h0100, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 16'h0000);
    chk("borrow_0059", 16'h0059, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h1000);
    cycle(1'b0, 1'b1, 1'b1, 16'h0000);
    chk("borrow_0959", 16'h0959, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b0, 1'b0, 16'h0010);
    cycle(1'b0, 1'b1, 1'b1, 16'h0000);
    chk("b2b_0009", 16'h0009, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 16'h0000);
    chk("b2b_0008", 16'h0008, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("hold_0008", 16'h0008, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_terminal_count();
    cycle(1'b0, 1'b0, 1'b0, 16'h0002);
    cycle(1'b0, 1'b1, 1'b1, 16'h0000);
    chk("tc_0001", 16'h0001, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 16'h0000);
    chk("tc_0000", 16'h0000, 1'b1, 1'b1, 1'b0);
    checks++;
    if (w_tc !== 1'b1) begin
      errors++; $display("FAIL wrap_tc_pulse: got %b expected 1", w_tc);
    end
    cycle(1'b0, 1'b1, 1'b1, 16'h0000);
    chk("tc_hold", 16'h0000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (w_count !== 16'h9959) begin
      errors++; $display("FAIL wrap_count: got %h expected 9959", w_count);
    end
    checks++;
    if ((w_tc !== 1'b0) || (w_zero !== 1'b0)) begin
      errors++; $display("FAIL wrap_flags: got tc=%b zero=%b expected tc=0 zero=0", w_tc, w_zero);
    end
  endtask

  task automatic test_invalid_load();
    cycle(1'b0, 1'b0, 1'b0, 16'h0030);
    chk("load_0030", 16'h0030, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0170);
    chk("reject_0170", 16'h0030, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("err_clears", 16'h0030, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h000A);
    chk("reject_000A", 16'h0030, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 16'h1234);
    chk("load_1234", 16'h1234, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_collisions();
    cycle(1'b0, 1'b0, 1'b1, 16'h0045);
    chk("load_wins", 16'h0045, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0001);
    cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    chk("load_zero_no_tc", 16'h0000, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0001);
    cycle(1'b1, 1'b1, 1'b1, 16'h0000);
    chk("clr_drops_tc", 16'h0000, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0512);
    cycle(1'b1, 1'b0, 1'b1, 16'h0045);
    chk("clr_wins", 16'h0000, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b1; loadn = 1'b1; en = 1'b0; data = 16'h0000;
    @(posedge clk);
    #1;
    clr = 1'b0;
    test_reset();
    test_mmss_borrow();
    test_back_to_back();
    test_terminal_count();
    test_invalid_load();
    test_collisions();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
